// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data-memory handshake: word RAM plus switch/LED MMIO.
// Optional build macro DMEM_CYCLE_COUNTER_EN maps a free-running cycle counter at MMIO_BASE+8.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_se,
    input  logic [1:0]  req_bs,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [31:0] SW_ADDR   = MMIO_BASE;
    localparam logic [31:0] LED_ADDR  = MMIO_BASE + 32'd4;
`ifdef DMEM_CYCLE_COUNTER_EN
    localparam logic [31:0] CNT_ADDR  = MMIO_BASE + 32'd8;
`endif

    localparam logic [1:0] BS_BYTE = 2'b00;
    localparam logic [1:0] BS_HALF = 2'b01;
    localparam logic [1:0] BS_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // Captured request
    logic        we_q, se_q;
    logic [1:0]  bs_q;
    logic [31:0] addr_q, wdata_q;

    // Results of the ACCESS-cycle decode, consumed in RESP
    logic        err_q, ram_hit_q;
    logic [31:0] mmio_q;

    logic [15:0] sw_meta, sw_sync;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] ram_q;

    logic        accept_c;
    logic        hit_ram_c, hit_sw_c, hit_led_c, hit_mmio_c;
    logic        misalign_c, acc_err_c, ram_wr_c, led_wr_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_rep_c, mmio_rd_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] load_c;

    logic        ready_d, rsp_valid_d, rsp_err_d;
    logic [31:0] rsp_rdata_d;

    logic [AW-1:0] idx_c;
    assign idx_c    = addr_q[AW+1:2];
    assign accept_c = req_valid && req_ready;

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cyc_q;
    logic        hit_cnt_c;

    always_ff @(posedge clk) begin
        if (rst) cyc_q <= 32'd0;
        else     cyc_q <= cyc_q + 32'd1;
    end
`endif

    // Address decode, alignment check and store lane generation for the ACCESS cycle
    always_comb begin
        hit_ram_c  = addr_q < RAM_BYTES;
        hit_sw_c   = addr_q == SW_ADDR;
        hit_led_c  = addr_q == LED_ADDR;
`ifdef DMEM_CYCLE_COUNTER_EN
        hit_cnt_c  = addr_q == CNT_ADDR;
        hit_mmio_c = hit_sw_c || hit_led_c || hit_cnt_c;
`else
        hit_mmio_c = hit_sw_c || hit_led_c;
`endif
        misalign_c = (bs_q == BS_HALF && addr_q[0]) ||
                     (bs_q == BS_WORD && addr_q[1:0] != 2'b00) ||
                     (bs_q == 2'b11);
        acc_err_c  = misalign_c ||
                     (!hit_ram_c && !hit_mmio_c) ||
                     (hit_mmio_c && bs_q != BS_WORD) ||
                     (hit_sw_c && we_q);
`ifdef DMEM_CYCLE_COUNTER_EN
        acc_err_c  = acc_err_c || (hit_cnt_c && we_q);
`endif
        ram_wr_c   = (state_q == ACCESS) && we_q && hit_ram_c && !acc_err_c;
        led_wr_c   = (state_q == ACCESS) && we_q && hit_led_c && !acc_err_c;

        be_c        = 4'b0000;
        wdata_rep_c = req_wdata_rep(bs_q, wdata_q);
        case (bs_q)
            BS_BYTE: be_c = 4'(4'b0001 << addr_q[1:0]);
            BS_HALF: be_c = addr_q[1] ? 4'b1100 : 4'b0011;
            BS_WORD: be_c = 4'b1111;
            default: be_c = 4'b0000;
        endcase

        mmio_rd_c = 32'd0;
        if (hit_sw_c)  mmio_rd_c = {16'd0, sw_sync};
        if (hit_led_c) mmio_rd_c = {16'd0, led_out};
`ifdef DMEM_CYCLE_COUNTER_EN
        if (hit_cnt_c) mmio_rd_c = cyc_q;
`endif
    end

    function automatic logic [31:0] req_wdata_rep(input logic [1:0] bs, input logic [31:0] wd);
        case (bs)
            BS_BYTE: req_wdata_rep = {4{wd[7:0]}};
            BS_HALF: req_wdata_rep = {2{wd[15:0]}};
            default: req_wdata_rep = wd;
        endcase
    endfunction

    // Load extraction: move the addressed byte/half to bit 0, then extend
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_c = ram_q[7:0];
            2'd1:    byte_c = ram_q[15:8];
            2'd2:    byte_c = ram_q[23:16];
            default: byte_c = ram_q[31:24];
        endcase
        half_c = addr_q[1] ? ram_q[31:16] : ram_q[15:0];
        case (bs_q)
            BS_BYTE: load_c = se_q ? {{24{byte_c[7]}}, byte_c} : {24'd0, byte_c};
            BS_HALF: load_c = se_q ? {{16{half_c[15]}}, half_c} : {16'd0, half_c};
            default: load_c = ram_q;
        endcase
    end

    // Next-state and next registered outputs
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
        case (state_q)
            IDLE:   if (accept_c) state_d = ACCESS;
            ACCESS: state_d = RESP;
            RESP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                if (!err_q && !we_q) rsp_rdata_d = ram_hit_q ? load_c : mmio_q;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            led_out   <= 16'd0;
            sw_meta   <= 16'd0;
            sw_sync   <= 16'd0;
        end else begin
            state_q   <= state_d;
            req_ready <= ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            sw_meta   <= sw_in;
            sw_sync   <= sw_meta;
            if (led_wr_c) led_out <= wdata_q[15:0];
        end
    end

    // Request capture and ACCESS-cycle results; no reset needed, qualified by state
    always_ff @(posedge clk) begin
        if (accept_c && state_q == IDLE) begin
            we_q    <= req_we;
            se_q    <= req_se;
            bs_q    <= req_bs;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
        if (state_q == ACCESS) begin
            err_q     <= acc_err_c;
            ram_hit_q <= hit_ram_c;
            mmio_q    <= mmio_rd_c;
        end
    end

    // Data RAM with per-byte write enable; writes are dropped while rst is high
    always_ff @(posedge clk) begin
        if (state_q == ACCESS) begin
            ram_q <= mem[idx_c];
            if (ram_wr_c && !rst) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_c[i]) mem[idx_c][8*i +: 8] <= wdata_rep_c[8*i +: 8];
                end
            end
        end
    end

endmodule
